// File: rtl/hicore_commit_ctrl_pkg.sv
// Shared definitions for the commit controller: state codes, writeback-info
// bit positions, the retired-instruction counter width and redirect classes.
package hicore_commit_ctrl_pkg;

  // One-hot sequencer states
  localparam logic [2:0] ST_RUN        = 3'b001;
  localparam logic [2:0] ST_FLUSH      = 3'b010;
  localparam logic [2:0] ST_FENCE_WAIT = 3'b100;

  // Writeback info layout
  localparam int INFO_EXC_BIT   = 0;
  localparam int INFO_MISP_BIT  = 1;
  localparam int INFO_CAUSE_LSB = 2;

  localparam int INSTRET_W = 64;

  // Why a retiring instruction redirects the front end
  typedef enum logic [2:0] {
    REDIR_NONE  = 3'd0,
    REDIR_TRAP  = 3'd1,
    REDIR_MRET  = 3'd2,
    REDIR_FENCE = 3'd3,
    REDIR_MISP  = 3'd4
  } redir_kind_e;

  // Priority: exception > mret > fence.i > mispredict
  function automatic redir_kind_e classify(input logic exc, input logic mret,
                                           input logic fence, input logic misp);
    if (exc)        return REDIR_TRAP;
    else if (mret)  return REDIR_MRET;
    else if (fence) return REDIR_FENCE;
    else if (misp)  return REDIR_MISP;
    else            return REDIR_NONE;
  endfunction

endpackage

// File: rtl/hicore_instret_cnt.sv
// Retired-instruction counter: increments when en is high, wraps naturally.
module hicore_instret_cnt
  import hicore_commit_ctrl_pkg::*;
#(
  parameter int W = INSTRET_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count
  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hicore_commit_ctrl.sv
// In-order retirement sequencer: handshakes the ROB head, issues RF/CSR
// writes one cycle later and sequences flush/redirect for traps, mret,
// fence.i and mispredicts.
module hicore_commit_ctrl
  import hicore_commit_ctrl_pkg::*;
#(
  parameter int PC_SIZE      = 32,
  parameter int REG_SIZE     = 32,
  parameter int RFIDX_WIDTH  = 5,
  parameter int CSRIDX_WIDTH = 12,
  parameter int WB_SIZE      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    rob_commit_valid,
  input  logic                    rob_commit_ready,
  input  logic                    rob_rd_need,
  input  logic [RFIDX_WIDTH-1:0]  rob_rd_idx,
  input  logic [REG_SIZE-1:0]     rob_rd_data,
  input  logic                    rob_csr_need,
  input  logic [CSRIDX_WIDTH-1:0] rob_csr_idx,
  input  logic [REG_SIZE-1:0]     rob_csr_data,
  input  logic                    rob_fence_i_op,
  input  logic                    rob_mret_op,
  input  logic [PC_SIZE-1:0]      rob_next_pc,
  input  logic [WB_SIZE-1:0]      rob_info,
  input  logic [PC_SIZE-1:0]      csr_mepc,
  input  logic [PC_SIZE-1:0]      csr_mtvec,
  output logic                    rf_wen,
  output logic [RFIDX_WIDTH-1:0]  rf_widx,
  output logic [REG_SIZE-1:0]     rf_wdata,
  output logic                    csr_wen,
  output logic [CSRIDX_WIDTH-1:0] csr_widx,
  output logic [REG_SIZE-1:0]     csr_wdata,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [PC_SIZE-1:0]      redirect_pc,
  output logic                    trap_valid,
  output logic [PC_SIZE-1:0]      trap_epc,
  output logic [REG_SIZE-1:0]     trap_cause,
  output logic                    mret_done,
  output logic                    fence_i_req,
  input  logic                    fence_i_ack,
  output logic [INSTRET_W-1:0]    instret
);

  localparam int CAUSE_W = WB_SIZE - INFO_CAUSE_LSB;

  logic [2:0]              state_q, state_d;
  logic                    fence_flag_q, fence_flag_d;
  logic [PC_SIZE-1:0]      target_q, target_d;
  logic                    rf_wen_q, rf_wen_d;
  logic [RFIDX_WIDTH-1:0]  rf_widx_q, rf_widx_d;
  logic [REG_SIZE-1:0]     rf_wdata_q, rf_wdata_d;
  logic                    csr_wen_q, csr_wen_d;
  logic [CSRIDX_WIDTH-1:0] csr_widx_q, csr_widx_d;
  logic [REG_SIZE-1:0]     csr_wdata_q, csr_wdata_d;
  logic                    redirect_valid_q, redirect_valid_d;
  logic                    trap_valid_q, trap_valid_d;
  logic [PC_SIZE-1:0]      trap_epc_q, trap_epc_d;
  logic [REG_SIZE-1:0]     trap_cause_q, trap_cause_d;
  logic                    mret_done_q, mret_done_d;
  logic                    fence_i_req_q, fence_i_req_d;

  logic        hs;
  logic        head_exc;
  redir_kind_e head_kind;

  assign rob_commit_valid = (state_q == ST_RUN);
  assign hs        = rob_commit_valid & rob_commit_ready;
  assign head_exc  = rob_info[INFO_EXC_BIT];
  assign head_kind = classify(head_exc, rob_mret_op, rob_fence_i_op,
                              rob_info[INFO_MISP_BIT]);

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d          = state_q;
    fence_flag_d     = fence_flag_q;
    target_d         = target_q;
    rf_wen_d         = 1'b0;
    rf_widx_d        = rf_widx_q;
    rf_wdata_d       = rf_wdata_q;
    csr_wen_d        = 1'b0;
    csr_widx_d       = csr_widx_q;
    csr_wdata_d      = csr_wdata_q;
    redirect_valid_d = 1'b0;
    trap_valid_d     = 1'b0;
    trap_epc_d       = trap_epc_q;
    trap_cause_d     = trap_cause_q;
    mret_done_d      = 1'b0;
    fence_i_req_d    = fence_i_req_q;

    case (state_q)
      ST_RUN: begin
        if (hs) begin
          // Writes land one cycle after the handshake; faulting entries never write
          rf_wen_d    = rob_rd_need & (rob_rd_idx != '0) & ~head_exc;
          rf_widx_d   = rob_rd_idx;
          rf_wdata_d  = rob_rd_data;
          csr_wen_d   = rob_csr_need & ~head_exc;
          csr_widx_d  = rob_csr_idx;
          csr_wdata_d = rob_csr_data;
          if (head_kind != REDIR_NONE) begin
            state_d      = ST_FLUSH;
            fence_flag_d = (head_kind == REDIR_FENCE);
            // fence.i defers its redirect until the I-cache acknowledges
            redirect_valid_d = (head_kind != REDIR_FENCE);
            mret_done_d      = (head_kind == REDIR_MRET);
            case (head_kind)
              REDIR_TRAP: target_d = csr_mtvec;
              REDIR_MRET: target_d = csr_mepc;
              default:    target_d = rob_next_pc;
            endcase
            if (head_kind == REDIR_TRAP) begin
              trap_valid_d = 1'b1;
              // The ROB reuses rd_data to carry the faulting PC
              trap_epc_d   = rob_rd_data[PC_SIZE-1:0];
              trap_cause_d = {{(REG_SIZE-CAUSE_W){1'b0}},
                              rob_info[WB_SIZE-1:INFO_CAUSE_LSB]};
            end
          end
        end
      end
      ST_FLUSH: begin
        fence_flag_d = 1'b0;
        if (fence_flag_q) begin
          state_d       = ST_FENCE_WAIT;
          fence_i_req_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FENCE_WAIT: begin
        if (fence_i_ack) begin
          state_d          = ST_RUN;
          fence_i_req_d    = 1'b0;
          redirect_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_RUN;
        fence_flag_d  = 1'b0;
        fence_i_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      fence_flag_q     <= 1'b0;
      target_q         <= '0;
      rf_wen_q         <= 1'b0;
      rf_widx_q        <= '0;
      rf_wdata_q       <= '0;
      csr_wen_q        <= 1'b0;
      csr_widx_q       <= '0;
      csr_wdata_q      <= '0;
      redirect_valid_q <= 1'b0;
      trap_valid_q     <= 1'b0;
      trap_epc_q       <= '0;
      trap_cause_q     <= '0;
      mret_done_q      <= 1'b0;
      fence_i_req_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      fence_flag_q     <= fence_flag_d;
      target_q         <= target_d;
      rf_wen_q         <= rf_wen_d;
      rf_widx_q        <= rf_widx_d;
      rf_wdata_q       <= rf_wdata_d;
      csr_wen_q        <= csr_wen_d;
      csr_widx_q       <= csr_widx_d;
      csr_wdata_q      <= csr_wdata_d;
      redirect_valid_q <= redirect_valid_d;
      trap_valid_q     <= trap_valid_d;
      trap_epc_q       <= trap_epc_d;
      trap_cause_q     <= trap_cause_d;
      mret_done_q      <= mret_done_d;
      fence_i_req_q    <= fence_i_req_d;
    end
  end

  hicore_instret_cnt #(.W(INSTRET_W)) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hs & ~head_exc),
    .count (instret)
  );

  assign flush          = (state_q == ST_FLUSH);
  assign rf_wen         = rf_wen_q;
  assign rf_widx        = rf_widx_q;
  assign rf_wdata       = rf_wdata_q;
  assign csr_wen        = csr_wen_q;
  assign csr_widx       = csr_widx_q;
  assign csr_wdata      = csr_wdata_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = target_q;
  assign trap_valid     = trap_valid_q;
  assign trap_epc       = trap_epc_q;
  assign trap_cause     = trap_cause_q;
  assign mret_done      = mret_done_q;
  assign fence_i_req    = fence_i_req_q;

endmodule

// File: doc/hicore_commit_ctrl.md
Name: hicore_commit_ctrl

Overview:
- In-order retirement sequencer between the reorder buffer's commit port and the architectural state.
- Drives the ROB commit handshake and performs register-file and CSR writes one entry per cycle.
- Sequences pipeline flush and front-end redirect for exceptions, mret, fence.i and branch mispredicts.
- Owns the 64-bit retired-instruction counter.

Parameters:
- PC_SIZE, 32, PC width
- REG_SIZE, 32, data width
- RFIDX_WIDTH, 5, register index width
- CSRIDX_WIDTH, 12, CSR index width
- WB_SIZE, 8, writeback info width. Bit 0 = exception, bit 1 = mispredict, bits [WB_SIZE-1:2] = exception cause.

Ports:
- clk in 1: clock
- rst_n in 1: asynchronous active-low reset
- rob_commit_valid out 1: commit request to the ROB
- rob_commit_ready in 1: head entry written back
- rob_rd_need in 1: head entry writes rd
- rob_rd_idx in RFIDX_WIDTH: head entry rd index
- rob_rd_data in REG_SIZE: head entry rd data; carries the faulting PC when info exception bit = 1
- rob_csr_need in 1: head entry writes a CSR
- rob_csr_idx in CSRIDX_WIDTH: head entry CSR index
- rob_csr_data in REG_SIZE: head entry CSR data
- rob_fence_i_op in 1: head entry is fence.i
- rob_mret_op in 1: head entry is mret
- rob_next_pc in PC_SIZE: sequential or resolved next PC of the head entry
- rob_info in WB_SIZE: head entry writeback info
- csr_mepc in PC_SIZE: current mepc
- csr_mtvec in PC_SIZE: current trap vector
- rf_wen out 1: register-file write enable
- rf_widx out RFIDX_WIDTH: register-file write index
- rf_wdata out REG_SIZE: register-file write data
- csr_wen out 1: CSR write enable
- csr_widx out CSRIDX_WIDTH: CSR write index
- csr_wdata out REG_SIZE: CSR write data
- flush out 1: pipeline and ROB flush pulse
- redirect_valid out 1: front-end redirect pulse
- redirect_pc out PC_SIZE: redirect target
- trap_valid out 1: trap taken pulse, to the CSR unit
- trap_epc out PC_SIZE: faulting PC
- trap_cause out REG_SIZE: zero-extended cause
- mret_done out 1: mret retired pulse
- fence_i_req out 1: I-cache invalidate request, held until acknowledged
- fence_i_ack in 1: invalidate done
- instret out 64: retired-instruction count

Behaviour:
- Reset: asynchronous and active-low. All outputs and registers are 0, and state = RUN. rst_n assertion mid-sequence aborts any FLUSH or FENCE_WAIT immediately.
- rob_commit_valid = (state == RUN); it is combinational from state only. A handshake (hs) = rob_commit_valid & rob_commit_ready.
- Writes, registered with 1-cycle latency after hs:
  - rf_wen = rd_need & (rd_idx != 0) & ~exception.
  - csr_wen = csr_need & ~exception.
  - idx/data are captured at hs; wen is 0 on all other cycles.
- instret increments by 1 on each hs without exception. It wraps from 2^64-1 to 0.
- Redirect classification at hs, in priority order exception > mret > fence_i > mispredict:
  - exception: next state FLUSH; captured target = csr_mtvec; trap_epc = rob_rd_data; trap_cause = info[WB_SIZE-1:2] zero-extended.
  - mret: FLUSH; target = csr_mepc.
  - fence_i: FLUSH with fence flag set; target = rob_next_pc.
  - mispredict: FLUSH; target = rob_next_pc.
  - none: remain in RUN, back-to-back commits allowed.
- FLUSH (exactly 1 cycle):
  - flush = 1 and rob_commit_valid = 0.
  - Without fence flag: redirect_valid = 1 with the captured target; trap_valid or mret_done pulse in this same cycle when applicable; next state RUN.
  - With fence flag: no redirect; fence_i_req rises next cycle; next state FENCE_WAIT.
- FENCE_WAIT:
  - fence_i_req = 1 and rob_commit_valid = 0.
  - On fence_i_ack: the next cycle pulses redirect_valid with the captured target, drops fence_i_req, and returns to RUN.
  - An ack may arrive in the first FENCE_WAIT cycle.
  - An ack seen outside FENCE_WAIT is ignored.
- The register/CSR write of the redirecting instruction issues in the FLUSH cycle, which is the normal 1-cycle latency. A commit and a flush never occur in the same cycle.
- All pulses are exactly 1 cycle wide.

Decomposition:
- Shared package (config include) holds:
  - state encodings RUN/FLUSH/FENCE_WAIT, one-hot 3 bits;
  - info bit positions: exception = 0, mispredict = 1, cause LSB = 2;
  - the instret width.
- One natural sub-module: hicore_instret_cnt, a 64-bit enabled counter with async reset.

Test Plan:
- Reset, then three back-to-back ready entries writing x1 = 0x11, x2 = 0x22, x0 = 0x33 -> rf_wen on cycles 1 and 2 only (the x0 write is suppressed); instret = 3; no flush.
- Exception entry, rd_data = 0x80000010, cause = 2, mtvec = 0x80000100 -> a single cycle with flush = redirect_valid = trap_valid = 1, redirect_pc = 0x80000100, trap_epc = 0x80000010, trap_cause = 2; rf_wen = 0; instret unchanged; commit_valid = 0 that cycle.
- mret entry, mepc = 0x80000200 -> flush, redirect_pc = 0x80000200, mret_done pulse; instret += 1.
- fence.i entry, next_pc = 0x80000044, ack held off 5 cycles -> flush pulse; fence_i_req high through the ack; redirect to 0x80000044 one cycle after ack; commit_valid = 0 throughout.
- Mispredict entry, next_pc = 0x80000400, plus exception and mispredict set together -> mtvec wins; mispredict-only case redirects to 0x80000400.
- rst_n asserted in FENCE_WAIT -> fence_i_req = 0, instret = 0, state RUN immediately; a late ack after reset causes no redirect.
